// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master engine between N_REQ
// requesters and sequences single-register read/write transactions on it.
module i2c_txn_arbiter #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_rnw,
  input  logic [N_REQ*7-1:0] req_addr,
  input  logic [N_REQ*8-1:0] req_reg,
  input  logic [N_REQ*8-1:0] req_wdata,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_rdata,
  output logic [1:0]         rsp_err,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               eng_cmd_valid,
  input  logic               eng_cmd_ready,
  output logic [1:0]         eng_cmd,
  output logic [7:0]         eng_wdata,
  input  logic               eng_done,
  input  logic               eng_nack,
  input  logic [7:0]         eng_rdata,
  output logic               eng_abort
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] LAST_WR = 3'd4;
  localparam logic [2:0] LAST_RD = 3'd6;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, sel_idx, cand;
  logic             sel_found;
  logic [N_REQ-1:0] sel_onehot, grant_q, ready_q;
  logic [2:0]       step_q, step_d, last_idx;
  logic             rnw_q;
  logic [6:0]       addr_q;
  logic [7:0]       reg_q, wdata_q, rdata_q;
  logic [1:0]       err_q;
  logic [CW-1:0]    cnt_q;
  logic             expired, accept, timeout;
  cmd_t             cur_cmd;
  logic [7:0]       cur_wdata;

  // Round-robin pick: first asserted request after the last owner, wrapping.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = PW'((32'(ptr_q) + k) % N_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  always_comb begin
    cur_cmd   = CMD_STOP;
    cur_wdata = '0;
    if (rnw_q) begin
      case (step_q)
        3'd0: cur_cmd = CMD_START;
        3'd1: begin cur_cmd = CMD_WRITE; cur_wdata = {addr_q, 1'b0}; end
        3'd2: begin cur_cmd = CMD_WRITE; cur_wdata = reg_q; end
        3'd3: cur_cmd = CMD_START;
        3'd4: begin cur_cmd = CMD_WRITE; cur_wdata = {addr_q, 1'b1}; end
        3'd5: cur_cmd = CMD_READ;
        default: cur_cmd = CMD_STOP;
      endcase
    end else begin
      case (step_q)
        3'd0: cur_cmd = CMD_START;
        3'd1: begin cur_cmd = CMD_WRITE; cur_wdata = {addr_q, 1'b0}; end
        3'd2: begin cur_cmd = CMD_WRITE; cur_wdata = reg_q; end
        3'd3: begin cur_cmd = CMD_WRITE; cur_wdata = wdata_q; end
        default: cur_cmd = CMD_STOP;
      endcase
    end
  end

  assign last_idx = rnw_q ? LAST_RD : LAST_WR;
  assign expired  = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // eng_done has priority over a coinciding step timeout.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    accept  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (expired) begin
          timeout = 1'b1;
          state_d = RESP;
        end else if (eng_cmd_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (eng_done) begin
          if (step_q == last_idx) begin
            state_d = RESP;
          end else begin
            state_d = ISSUE;
            step_d  = (cur_cmd == CMD_WRITE && eng_nack) ? last_idx : step_q + 3'd1;
          end
        end else if (expired) begin
          timeout = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q   <= PW'(N_REQ - 1);
      grant_q <= '0;
      ready_q <= '0;
      step_q  <= '0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ready_q <= '0;
      step_q  <= accept ? '0 : step_d;
      if (accept) begin
        ready_q <= sel_onehot;
        grant_q <= sel_onehot;
        ptr_q   <= sel_idx;
        rnw_q   <= req_rnw[sel_idx];
        addr_q  <= req_addr[32'(sel_idx)*7 +: 7];
        reg_q   <= req_reg[32'(sel_idx)*8 +: 8];
        wdata_q <= req_wdata[32'(sel_idx)*8 +: 8];
        rdata_q <= '0;
        err_q   <= '0;
      end
      if (state_q == WAIT && eng_done) begin
        if (cur_cmd == CMD_READ) rdata_q <= eng_rdata;
        if (cur_cmd == CMD_WRITE && eng_nack) err_q <= 2'b01;
      end
      if (timeout) err_q <= 2'b10;
      if (state_q == RESP) grant_q <= '0;
      // Per-step budget restarts every time a new command is about to be issued.
      if (state_d == ISSUE && state_q != ISSUE) cnt_q <= '0;
      else if (state_q == ISSUE || state_q == WAIT) cnt_q <= cnt_q + CW'(1);
    end
  end

  assign req_ready     = ready_q;
  assign grant         = grant_q;
  assign busy          = (state_q != IDLE);
  assign eng_cmd_valid = (state_q == ISSUE);
  assign eng_cmd       = (state_q == ISSUE) ? cur_cmd : CMD_START;
  assign eng_wdata     = (state_q == ISSUE) ? cur_wdata : '0;
  assign eng_abort     = timeout;
  assign rsp_valid     = (state_q == RESP) ? grant_q : '0;
  assign rsp_rdata     = (state_q == RESP) ? rdata_q : '0;
  assign rsp_err       = (state_q == RESP) ? err_q : '0;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a small behavioural engine model that
// logs every command handshake and answers with configurable ACK/NACK/hang.
module tb_i2c_txn_arbiter;
  localparam int N  = 2;
  localparam int TO = 50;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_rnw = '0;
  logic [N*7-1:0] req_addr = '0;
  logic [N*8-1:0] req_reg = '0;
  logic [N*8-1:0] req_wdata = '0;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_rdata;
  logic [1:0]     rsp_err;
  logic [N-1:0]   grant;
  logic           busy;
  logic           eng_cmd_valid;
  logic           eng_cmd_ready = 1'b1;
  logic [1:0]     eng_cmd;
  logic [7:0]     eng_wdata;
  logic           eng_done = 1'b0;
  logic           eng_nack = 1'b0;
  logic [7:0]     eng_rdata = '0;
  logic           eng_abort;

  i2c_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .grant(grant), .busy(busy),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
    .eng_cmd(eng_cmd), .eng_wdata(eng_wdata),
    .eng_done(eng_done), .eng_nack(eng_nack), .eng_rdata(eng_rdata),
    .eng_abort(eng_abort)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic        hang_write = 1'b0;
  logic        hang_read  = 1'b0;
  logic        nack_write = 1'b0;
  logic [7:0]  rd_val     = 8'h77;
  logic [9:0]  log_q[$];
  logic [9:0]  exp_log[$];
  int unsigned issue_cyc = 0;
  bit          pending = 1'b0;
  logic        pend_nack = 1'b0;
  logic [7:0]  pend_rdata = '0;

  // Engine model: command taken at the handshake edge, done pulsed one cycle later.
  always @(negedge clk) begin
    eng_done  = 1'b0;
    eng_nack  = 1'b0;
    eng_rdata = '0;
    if (!rstn) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        eng_done  = 1'b1;
        eng_nack  = pend_nack;
        eng_rdata = pend_rdata;
        pending   = 1'b0;
      end
      if (eng_cmd_valid && eng_cmd_ready) begin
        log_q.push_back({eng_cmd, (eng_cmd == 2'b01) ? eng_wdata : 8'h00});
        issue_cyc  = cyc;
        pend_nack  = 1'b0;
        pend_rdata = '0;
        case (eng_cmd)
          2'b01:   begin pending = !hang_write; pend_nack = nack_write; end
          2'b10:   begin pending = !hang_read;  pend_rdata = rd_val; end
          default: pending = 1'b1;
        endcase
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int base);
    chk({tag, "_len"}, 32'(log_q.size() - base), 32'(exp_log.size()));
    for (int k = 0; k < exp_log.size() && base + k < log_q.size(); k++)
      chk($sformatf("%s_cmd%0d", tag, k), 32'(log_q[base + k]), 32'(exp_log[k]));
  endtask

  task automatic set_desc(input int i, input bit rnw, input logic [6:0] a,
                          input logic [7:0] r, input logic [7:0] wd);
    req_rnw[i]          = rnw;
    req_addr[i*7 +: 7]  = a;
    req_reg[i*8 +: 8]   = r;
    req_wdata[i*8 +: 8] = wd;
  endtask

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin tick(); seen = (req_ready != '0); end
  endtask

  task automatic wait_rsp();
    bit seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin tick(); seen = (rsp_valid != '0); end
  endtask

  task automatic run_txn(input string tag, input int i, input bit rnw, input logic [6:0] a,
                         input logic [7:0] r, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input logic [1:0] exp_err,
                         output int unsigned lat);
    logic [N-1:0] oh;
    int unsigned  t0;
    oh = N'(1) << i;
    set_desc(i, rnw, a, r, wd);
    t0 = cyc;
    req_valid[i] = 1'b1;
    wait_ready();
    chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
    chk({tag, "_grant"}, 32'(grant), 32'(oh));
    req_valid[i] = 1'b0;
    wait_rsp();
    lat = cyc - t0;
    chk({tag, "_rsp"}, 32'(rsp_valid), 32'(oh));
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    tick();
    chk({tag, "_idle"}, 32'({grant, busy, rsp_valid}), 32'(0));
  endtask

  initial begin
    int unsigned lat;
    int          base;
    logic [N-1:0] exp_g, g;
    bit          steady, seen;

    tick(); tick();
    chk("rst_outs", 32'({req_ready, rsp_valid, grant, busy, eng_cmd_valid, eng_abort,
                         rsp_err, rsp_rdata, eng_cmd, eng_wdata}), 32'(0));
    rstn = 1'b1;
    tick();

    // Single write from requester 0.
    base = log_q.size();
    run_txn("wr0", 0, 1'b0, 7'h58, 8'h12, 8'hFF, 8'h00, 2'b00, lat);
    chk("wr0_latency", lat, 32'd11);
    exp_log = '{10'h000, 10'h1B0, 10'h112, 10'h1FF, 10'h300};
    chk_log("wr0", base);

    // Single read from requester 1 with repeated START.
    base = log_q.size();
    run_txn("rd1", 1, 1'b1, 7'h55, 8'h12, 8'h00, 8'h77, 2'b00, lat);
    chk("rd1_latency", lat, 32'd15);
    exp_log = '{10'h000, 10'h1AA, 10'h112, 10'h000, 10'h1AB, 10'h200, 10'h300};
    chk_log("rd1", base);

    // Both requesters contend and re-request; ownership alternates 0,1,0,1.
    set_desc(0, 1'b0, 7'h10, 8'h01, 8'h11);
    set_desc(1, 1'b0, 7'h20, 8'h02, 8'h22);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_ready();
      chk($sformatf("cont%0d_ready", k), 32'(req_ready), 32'(exp_g));
      g = grant;
      chk($sformatf("cont%0d_grant", k), 32'(g), 32'(exp_g));
      req_valid = req_valid & ~exp_g;
      steady = 1'b1;
      seen   = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
        tick();
        seen = (rsp_valid != '0);
        if (grant !== g || req_ready !== '0) steady = 1'b0;
      end
      chk($sformatf("cont%0d_steady", k), 32'(steady), 32'd1);
      chk($sformatf("cont%0d_rsp", k), 32'(rsp_valid), 32'(exp_g));
      chk($sformatf("cont%0d_err", k), 32'(rsp_err), 32'(0));
      if (k < 2) req_valid = req_valid | exp_g;
    end
    req_valid = '0;
    tick();

    // Slave NACKs the address byte: straight to STOP.
    nack_write = 1'b1;
    base = log_q.size();
    run_txn("nack", 0, 1'b0, 7'h20, 8'h34, 8'h56, 8'h00, 2'b01, lat);
    nack_write = 1'b0;
    exp_log = '{10'h000, 10'h140, 10'h300};
    chk_log("nack", base);

    // Engine never finishes a WRITE: abort after TO-1 cycles, no STOP.
    hang_write = 1'b1;
    base = log_q.size();
    set_desc(0, 1'b0, 7'h58, 8'h12, 8'hFF);
    req_valid[0] = 1'b1;
    wait_ready();
    chk("to_ready", 32'(req_ready), 32'(2'b01));
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin tick(); seen = eng_abort; end
    chk("to_abort_seen", 32'(seen), 32'd1);
    chk("to_abort_time", cyc - issue_cyc, 32'(TO - 1));
    tick();
    chk("to_abort_width", 32'(eng_abort), 32'd0);
    chk("to_rsp", 32'(rsp_valid), 32'(2'b01));
    chk("to_err", 32'(rsp_err), 32'(2'b10));
    chk("to_rdata", 32'(rsp_rdata), 32'(0));
    hang_write = 1'b0;
    exp_log = '{10'h000, 10'h1B0};
    chk_log("to", base);
    tick();

    // Next request after the timeout runs normally.
    base = log_q.size();
    run_txn("post", 1, 1'b0, 7'h11, 8'h01, 8'hA5, 8'h00, 2'b00, lat);
    exp_log = '{10'h000, 10'h122, 10'h101, 10'h1A5, 10'h300};
    chk_log("post", base);

    // Reset while the READ is outstanding.
    hang_read = 1'b1;
    base = log_q.size();
    set_desc(0, 1'b1, 7'h55, 8'h34, 8'h00);
    req_valid[0] = 1'b1;
    wait_ready();
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin tick(); seen = (log_q.size() - base >= 6); end
    tick(); tick();
    chk("mrst_grant_before", 32'(grant), 32'(2'b01));
    rstn = 1'b0;
    #1;
    chk("mrst_outs", 32'({req_ready, rsp_valid, grant, busy, eng_cmd_valid, eng_abort,
                          rsp_err, rsp_rdata, eng_cmd, eng_wdata}), 32'(0));
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin tick(); if (rsp_valid != '0) seen = 1'b1; end
    hang_read = 1'b0;
    rstn = 1'b1;
    for (int n = 0; n < 3; n++) begin tick(); if (rsp_valid != '0) seen = 1'b1; end
    chk("mrst_no_rsp", 32'(seen), 32'd0);

    set_desc(0, 1'b0, 7'h01, 8'h02, 8'h03);
    set_desc(1, 1'b0, 7'h04, 8'h05, 8'h06);
    req_valid = 2'b11;
    wait_ready();
    chk("mrst_first_ready", 32'(req_ready), 32'(2'b01));
    req_valid = '0;
    wait_rsp();
    chk("mrst_first_rsp", 32'(rsp_valid), 32'(2'b01));
    chk("mrst_first_err", 32'(rsp_err), 32'(0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
